alu_cmd_sequencer: RTL and testbench

//  Initiator side of the TotalALU port protocol: accepts ALU commands over valid/ready and drives Signal/dataA/dataB.

---
 rtl/alu_cmd_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of TotalALU: times single-cycle ops and DIVU, then fetches HI/LO.
// Optional SELF_CHECK_EN adds cmd_exp / mismatch / err_count result checking.
module alu_cmd_sequencer #(
  parameter int          DIV_CYCLES = 33,
  parameter int          GAP_CYCLES = 2,
  parameter logic [5:0]  IDLE_SIG   = 6'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic [5:0]  alu_signal,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  input  logic [31:0] alu_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [31:0] res_hi,
  output logic        res_err
`ifdef SELF_CHECK_EN
  ,
  input  logic [31:0] cmd_exp,
  output logic        mismatch,
  output logic [15:0] err_count
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_DWAIT = 3'd2;
  localparam logic [2:0] S_DGAP  = 3'd3;
  localparam logic [2:0] S_MFHI  = 3'd4;
  localparam logic [2:0] S_MFLO  = 3'd5;
  localparam logic [2:0] S_RESP  = 3'd6;

  localparam logic [5:0] OP_AND  = 6'd36;
  localparam logic [5:0] OP_OR   = 6'd37;
  localparam logic [5:0] OP_ADD  = 6'd32;
  localparam logic [5:0] OP_SUB  = 6'd34;
  localparam logic [5:0] OP_SLT  = 6'd42;
  localparam logic [5:0] OP_SRL  = 6'd2;
  localparam logic [5:0] OP_DIVU = 6'd27;
  localparam logic [5:0] OP_MFHI = 6'd16;
  localparam logic [5:0] OP_MFLO = 6'd18;

  localparam logic [5:0] DIV_LD = 6'(DIV_CYCLES - 1);
  localparam logic [5:0] GAP_LD = 6'(GAP_CYCLES - 1);

  logic [2:0]  state;
  logic [5:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [5:0]  cnt;
  logic        is_alu;
  logic        is_div;

  always_comb begin
    is_alu = 1'b0;
    is_div = 1'b0;
    unique case (1'b1)
      cmd_op == OP_AND,
      cmd_op == OP_OR,
      cmd_op == OP_ADD,
      cmd_op == OP_SUB,
      cmd_op == OP_SLT,
      cmd_op == OP_SRL:  is_alu = 1'b1;
      cmd_op == OP_DIVU: is_div = 1'b1;
      default: ;
    endcase
  end

  // Zero-length wait or gap phases are skipped entirely.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= 6'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      cnt      <= 6'd0;
      res_data <= 32'd0;
      res_hi   <= 32'd0;
      res_err  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q     <= cmd_op;
            a_q      <= cmd_a;
            b_q      <= cmd_b;
            res_data <= 32'd0;
            res_hi   <= 32'd0;
            res_err  <= 1'b0;
            if (is_alu) begin
              state <= S_EXEC;
            end else if (is_div) begin
              if (DIV_CYCLES != 0) begin
                state <= S_DWAIT;
                cnt   <= DIV_LD;
              end else if (GAP_CYCLES != 0) begin
                state <= S_DGAP;
                cnt   <= GAP_LD;
              end else begin
                state <= S_MFHI;
              end
            end else begin
              state   <= S_RESP;
              res_err <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          res_data <= alu_out;
          state    <= S_RESP;
        end
        S_DWAIT: begin
          if (cnt == 6'd0) begin
            if (GAP_CYCLES != 0) begin
              state <= S_DGAP;
              cnt   <= GAP_LD;
            end else begin
              state <= S_MFHI;
            end
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        S_DGAP: begin
          if (cnt == 6'd0) state <= S_MFHI;
          else             cnt   <= cnt - 6'd1;
        end
        S_MFHI: begin
          res_hi <= alu_out;
          state  <= S_MFLO;
        end
        S_MFLO: begin
          res_data <= alu_out;
          state    <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_signal = IDLE_SIG;
    unique case (state)
      S_EXEC:  alu_signal = op_q;
      S_DWAIT: alu_signal = OP_DIVU;
      S_MFHI:  alu_signal = OP_MFHI;
      S_MFLO:  alu_signal = OP_MFLO;
      default: alu_signal = IDLE_SIG;
    endcase
  end

  assign cmd_ready = (state == S_IDLE);
  assign res_valid = (state == S_RESP);
  assign alu_dataA = a_q;
  assign alu_dataB = b_q;

`ifdef SELF_CHECK_EN
  logic [31:0] exp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q     <= 32'd0;
      mismatch  <= 1'b0;
      err_count <= 16'd0;
    end else begin
      mismatch <= 1'b0;
      if (cmd_valid && cmd_ready) exp_q <= cmd_exp;
      if (res_valid && res_ready && res_data != exp_q) begin
        mismatch <= 1'b1;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized bench for alu_cmd_sequencer with a TotalALU model and a result reference.
// Define SELF_CHECK_EN to also exercise the result-checking ports.
module tb_alu_cmd_sequencer;

  localparam int DC = 33;
  localparam int GC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [5:0]  alu_signal;
  logic [31:0] alu_dataA;
  logic [31:0] alu_dataB;
  logic [31:0] alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [31:0] res_hi;
  logic        res_err;
`ifdef SELF_CHECK_EN
  logic [31:0] cmd_exp;
  logic        mismatch;
  logic [15:0] err_count;
  int          sb_err = 0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .DIV_CYCLES(DC),
    .GAP_CYCLES(GC),
    .IDLE_SIG(6'd0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_a(cmd_a),
    .cmd_b(cmd_b),
    .alu_signal(alu_signal),
    .alu_dataA(alu_dataA),
    .alu_dataB(alu_dataB),
    .alu_out(alu_out),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_hi(res_hi),
    .res_err(res_err)
`ifdef SELF_CHECK_EN
    ,
    .cmd_exp(cmd_exp),
    .mismatch(mismatch),
    .err_count(err_count)
`endif
  );

  // TotalALU model: combinational ops, HI/LO written while DIVU is applied.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always @(posedge clk) begin
    if (alu_signal == 6'd27 && alu_dataB != 32'd0) begin
      m_hi <= alu_dataA % alu_dataB;
      m_lo <= alu_dataA / alu_dataB;
    end
  end

  always_comb begin
    alu_out = 32'd0;
    case (alu_signal)
      6'd36: alu_out = alu_dataA & alu_dataB;
      6'd37: alu_out = alu_dataA | alu_dataB;
      6'd32: alu_out = alu_dataA + alu_dataB;
      6'd34: alu_out = alu_dataA - alu_dataB;
      6'd42: alu_out = {31'd0, $signed(alu_dataA) < $signed(alu_dataB)};
      6'd2:  alu_out = alu_dataA >> alu_dataB[4:0];
      6'd16: alu_out = m_hi;
      6'd18: alu_out = m_lo;
      default: alu_out = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_model(input logic [5:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] d,
                                    output logic [31:0] h,
                                    output logic e,
                                    output int l);
    d = 32'd0;
    h = 32'd0;
    e = 1'b0;
    l = 2;
    case (op)
      6'd36: d = a & b;
      6'd37: d = a | b;
      6'd32: d = a + b;
      6'd34: d = a - b;
      6'd42: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd2:  d = a >> b[4:0];
      6'd27: begin
        d = a / b;
        h = a % b;
        l = 2 + DC + GC + 1;
      end
      default: begin
        e = 1'b1;
        l = 1;
      end
    endcase
  endfunction

  task automatic run_cmd(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic bad_exp,
                         input int hold);
    logic [31:0] ed;
    logic [31:0] eh;
    logic        ee;
    int          el;
    int          lat;
    logic [5:0]  q[$];
    logic [5:0]  eq[$];
    ref_model(op, a, b, ed, eh, ee, el);
    if (op == 6'd27) begin
      repeat (DC) eq.push_back(6'd27);
      repeat (GC) eq.push_back(6'd0);
      eq.push_back(6'd16);
      eq.push_back(6'd18);
    end else if (!ee) begin
      eq.push_back(op);
    end
    @(negedge clk);
    chk("ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
`ifdef SELF_CHECK_EN
    cmd_exp = bad_exp ? ~ed : ed;
    if (bad_exp) sb_err++;
`endif
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 100) begin
      q.push_back(alu_signal);
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(el));
    chk("trace_len", 64'(q.size()), 64'(eq.size()));
    for (int i = 0; i < q.size(); i++)
      if (i < eq.size()) chk("trace", 64'(q[i]), 64'(eq[i]));
    chk("res_data", 64'(res_data), 64'(ed));
    chk("res_hi", 64'(res_hi), 64'(eh));
    chk("res_err", 64'(res_err), 64'(ee));
    chk("resp_sig", 64'(alu_signal), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_data", 64'(res_data), 64'(ed));
      chk("hold_ready", 64'(cmd_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("post_valid", 64'(res_valid), 64'd0);
    chk("post_ready", 64'(cmd_ready), 64'd1);
`ifdef SELF_CHECK_EN
    chk("mismatch", 64'(mismatch), 64'(bad_exp));
    chk("err_count", 64'(err_count), 64'(sb_err));
    @(negedge clk);
    chk("mismatch_low", 64'(mismatch), 64'd0);
`endif
  endtask

  task automatic reset_mid_divu();
    int seen;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 6'd27;
    cmd_a     = 32'd100;
    cmd_b     = 32'd7;
`ifdef SELF_CHECK_EN
    cmd_exp = 32'd14;
`endif
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("div_busy", 64'(alu_signal), 64'd27);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_sig", 64'(alu_signal), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_dataA", 64'(alu_dataA), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (alu_signal != 6'd0 || res_valid) seen++;
    end
    chk("no_reissue", 64'(seen), 64'd0);
  endtask

  logic [5:0] ops[10] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42,
                          6'd2, 6'd27, 6'd63, 6'd0, 6'd5};

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [5:0]  rop;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 6'd0;
    cmd_a     = 32'd0;
    cmd_b     = 32'd0;
    res_ready = 1'b0;
`ifdef SELF_CHECK_EN
    cmd_exp = 32'd0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_alu_sig", 64'(alu_signal), 64'd0);
    chk("rst_dataA", 64'(alu_dataA), 64'd0);
    chk("rst_dataB", 64'(alu_dataB), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_hi", 64'(res_hi), 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
`ifdef SELF_CHECK_EN
    chk("rst_mismatch", 64'(mismatch), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
`endif

    run_cmd(6'd32, 32'd5, 32'd7, 1'b0, 0);
    run_cmd(6'd27, 32'd100, 32'd7, 1'b0, 0);
    run_cmd(6'd34, 32'd3, 32'd5, 1'b0, 5);
    reset_mid_divu();
    run_cmd(6'd63, 32'd1, 32'd2, 1'b0, 1);
    run_cmd(6'd42, 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_cmd(6'd2, 32'h8000_0000, 32'd31, 1'b0, 0);
    run_cmd(6'd27, 32'hFFFF_FFFF, 32'd1, 1'b0, 2);
`ifdef SELF_CHECK_EN
    run_cmd(6'd37, 32'd1, 32'd2, 1'b1, 0);
    run_cmd(6'd37, 32'd1, 32'd2, 1'b0, 0);
`endif

    for (int n = 0; n < 25; n++) begin
      rop = ops[$urandom_range(0, 9)];
      ra  = $urandom;
      rb  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (rb == 32'd0) rb = 32'd1;
      run_cmd(rop, ra, rb, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
